nc_frame_ctrl: RTL and testbench
================================

Name: nc_frame_ctrl

Overview:
- Frame sequencer for the 128-entry shift FIFO between the audio sample stream and the FFT engine in the noise-cancelling core.
- Operates on one frame at a time. It gates incoming samples into the FIFO until a full frame is held, then starts the FFT. It drains the frame into the FFT in one gap-free burst and waits for the FFT completion signal before accepting the next frame.
- Also counts frames and flags overrun, timeout and FIFO error conditions.

Parameters:
- FRAME_LEN, 128, samples per frame; must equal the FIFO depth.
- CNT_W, 8, width of the write and read counters; must satisfy 2^CNT_W > FRAME_LEN.
- TIMEOUT, 4096, maximum cycles spent in WAIT_FFT before aborting.
- FCNT_W, 16, width of frame_cnt and drop_cnt.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- n_rst  in  1  synchronous reset, active low.
- enable  in  1  run request from the register interface.
- clr_status  in  1  one-cycle pulse; clears the sticky flags and drop_cnt.
- sample_valid  in  1  a new audio sample is present on the FIFO data_in this cycle.
- fifo_ready  in  1  FIFO read-data-valid, one cycle after rd_ce.
- fifo_error  in  1  FIFO error status.
- fft_edone  in  1  one-cycle pulse from the FFT: frame processed.
- fifo_wr_ce  out  1  FIFO write enable.
- fifo_rd_ce  out  1  FIFO read enable.
- fifo_hold  out  1  drives the FIFO fft_edone pin; freezes or clears the FIFO.
- fft_start  out  1  one-cycle pulse: frame drain begins.
- fft_din_valid  out  1  data_out of the FIFO is a valid FFT input sample.
- frame_done  out  1  one-cycle pulse: frame completed.
- frame_cnt  out  FCNT_W  number of completed frames; wraps.
- drop_cnt  out  FCNT_W  samples dropped while not in FILL; saturates.
- overrun  out  1  sticky: a sample was dropped.
- timeout  out  1  sticky: WAIT_FFT exceeded TIMEOUT.
- err  out  1  sticky: fifo_error was seen.
- state  out  2  current state: IDLE=0, FILL=1, DRAIN=2, WAIT_FFT=3.

Behaviour:
- Reset (n_rst=0 at a clk edge):
  - state=IDLE; all counters, sticky flags and pulses are 0.
  - Outputs fifo_hold=1, fifo_wr_ce=0, fifo_rd_ce=0.
- Combinational outputs:
  - fifo_wr_ce = (state==FILL) & sample_valid.
  - fifo_rd_ce = (state==DRAIN).
  - fifo_hold = (state==IDLE) | (state==WAIT_FFT).
  - fft_din_valid = fifo_ready & (state==DRAIN | previous state==DRAIN).
  - wr_ce and rd_ce are never high in the same cycle.
- IDLE:
  - wr_cnt=0 and rd_cnt=0.
  - enable=1 -> FILL on the next edge.
- FILL:
  - Each fifo_wr_ce increments wr_cnt.
  - The write with wr_cnt==FRAME_LEN-1 -> DRAIN. fft_start is registered high for the first DRAIN cycle.
  - enable=0 -> IDLE and the partial frame is discarded. The FIFO self-clears because hold=1 with no wr/rd.
- DRAIN:
  - rd_ce is high for exactly FRAME_LEN consecutive cycles, counted by rd_cnt.
  - After the cycle with rd_cnt==FRAME_LEN-1 -> WAIT_FFT.
  - fft_din_valid covers the FRAME_LEN cycles that lag rd_ce by one.
  - enable=0 does not abort DRAIN.
- WAIT_FFT:
  - A cycle counter runs.
  - fft_edone -> frame_cnt+1 and a frame_done pulse. Next state is FILL if enable=1, otherwise IDLE. Counters are cleared.
  - Counter reaching TIMEOUT without fft_edone -> timeout=1, then IDLE.
- Drops: sample_valid in any state other than FILL sets overrun=1 and increments drop_cnt, saturating at all-ones.
- FIFO error: fifo_error=1 in any state sets err=1 and forces IDLE on the next edge, taking priority over all other transitions.
- clr_status:
  - Clears overrun, timeout, err and drop_cnt. It does not clear frame_cnt.
  - If it coincides with a new set event, the set wins.
- fft_edone outside WAIT_FFT is ignored.
- Reset mid-frame returns to the reset state on the next edge, regardless of the current state.
- Latency: the last FILL write to fft_start is 1 cycle. fft_start to the last fft_din_valid is FRAME_LEN cycles.

Test Plan:
- Reset, enable=1, 128 back-to-back sample_valid -> exactly 128 wr_ce; fft_start on the cycle after the 128th write; 128 consecutive rd_ce; 128 fft_din_valid lagging by 1; state=3.
- fft_edone after 50 WAIT cycles with enable=1 -> frame_done pulse, frame_cnt=1, state=FILL. A second frame fed with sample_valid every 3rd cycle -> frame_cnt=2 after its edone.
- sample_valid held high through DRAIN (128 cycles) -> drop_cnt=128, overrun=1. Then a clr_status pulse -> drop_cnt=0, overrun=0, frame_cnt unchanged.
- enable=0 after 60 FILL writes -> IDLE next cycle, fifo_hold=1. Re-enable plus 128 writes -> fft_start only after the 128th new write.
- No fft_edone for 4096 WAIT cycles -> timeout=1, state=IDLE. fifo_error pulse during DRAIN -> err=1, state=IDLE next edge, rd_ce=0.
- n_rst=0 for one cycle mid-DRAIN (rd_cnt=40) -> all outputs at reset values, state=0, frame_cnt=0.

Source files
------------

// File: rtl/nc_frame_ctrl.sv
// Frame sequencer between the audio sample stream, the 128-entry shift FIFO and the FFT engine.
// Fills one frame, drains it gap-free into the FFT, waits for completion, and keeps status counters/flags.
module nc_frame_ctrl #(
  parameter int FRAME_LEN = 128,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 4096,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              enable,
  input  logic              clr_status,
  input  logic              sample_valid,
  input  logic              fifo_ready,
  input  logic              fifo_error,
  input  logic              fft_edone,
  output logic              fifo_wr_ce,
  output logic              fifo_rd_ce,
  output logic              fifo_hold,
  output logic              fft_start,
  output logic              fft_din_valid,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [FCNT_W-1:0] drop_cnt,
  output logic              overrun,
  output logic              timeout,
  output logic              err,
  output logic [1:0]        state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              fft_start_q, fft_start_d;
  logic              frame_done_q, frame_done_d;
  logic              prev_drain_q, prev_drain_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [FCNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [FCNT_W-1:0] drop_base;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
  logic              drop;

  assign fifo_wr_ce    = (state_q == S_FILL) & sample_valid;
  assign fifo_rd_ce    = (state_q == S_DRAIN);
  assign fifo_hold     = (state_q == S_IDLE) | (state_q == S_WAIT);
  // FIFO read data arrives one cycle after rd_ce, so the last valid sample lands in the first WAIT cycle.
  assign fft_din_valid = fifo_ready & ((state_q == S_DRAIN) | prev_drain_q);
  assign fft_start     = fft_start_q;
  assign frame_done    = frame_done_q;
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign overrun       = overrun_q;
  assign timeout       = timeout_q;
  assign err           = err_q;
  assign state         = state_q;

  assign drop = sample_valid & (state_q != S_FILL);

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    fft_start_d  = 1'b0;
    frame_done_d = 1'b0;
    prev_drain_d = (state_q == S_DRAIN);
    frame_cnt_d  = frame_cnt_q;

    // Clear first so that a coincident set event wins.
    overrun_d = clr_status ? 1'b0 : overrun_q;
    timeout_d = clr_status ? 1'b0 : timeout_q;
    err_d     = (clr_status ? 1'b0 : err_q) | fifo_error;
    drop_base = clr_status ? '0 : drop_cnt_q;
    drop_cnt_d = drop_base;
    if (drop) begin
      overrun_d = 1'b1;
      if (drop_base != '1) drop_cnt_d = drop_base + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        wr_cnt_d   = '0;
        rd_cnt_d   = '0;
        wait_cnt_d = '0;
        if (enable) state_d = S_FILL;
      end
      S_FILL: begin
        if (!enable) begin
          state_d  = S_IDLE;
          wr_cnt_d = '0;
        end else if (sample_valid) begin
          if (wr_cnt_q == LAST_IDX) begin
            state_d     = S_DRAIN;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            fft_start_d = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (rd_cnt_q == LAST_IDX) begin
          state_d    = S_WAIT;
          rd_cnt_d   = '0;
          wait_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: begin
        if (fft_edone) begin
          frame_cnt_d  = frame_cnt_q + 1'b1;
          frame_done_d = 1'b1;
          state_d      = enable ? S_FILL : S_IDLE;
          wait_cnt_d   = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d  = 1'b1;
          state_d    = S_IDLE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
    endcase

    // A FIFO error overrides every other transition, including frame completion and timeout.
    if (fifo_error) begin
      state_d      = S_IDLE;
      wr_cnt_d     = '0;
      rd_cnt_d     = '0;
      wait_cnt_d   = '0;
      fft_start_d  = 1'b0;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      timeout_d    = clr_status ? 1'b0 : timeout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= S_IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wait_cnt_q   <= '0;
      fft_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
      prev_drain_q <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      fft_start_q  <= fft_start_d;
      frame_done_q <= frame_done_d;
      prev_drain_q <= prev_drain_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_nc_frame_ctrl.sv
// Scoreboard bench for nc_frame_ctrl: a frame-level reference model queues the expected outputs
// for every cycle and an independent monitor compares them against the DUT.
module tb_nc_frame_ctrl;

  localparam int FRAME_LEN = 128;
  localparam int TIMEOUT   = 4096;
  localparam int IDLE = 0, FILL = 1, DRAIN = 2, WAITF = 3;

  logic clk = 1'b0;
  logic n_rst, enable, clr_status, sample_valid, fifo_ready, fifo_error, fft_edone;
  logic fifo_wr_ce, fifo_rd_ce, fifo_hold, fft_start, fft_din_valid, frame_done;
  logic [15:0] frame_cnt, drop_cnt;
  logic overrun, timeout, err;
  logic [1:0] state;
  logic rd_prev = 1'b0;
  logic noise;

  always #5 clk = ~clk;

  nc_frame_ctrl dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .clr_status(clr_status),
    .sample_valid(sample_valid), .fifo_ready(fifo_ready), .fifo_error(fifo_error),
    .fft_edone(fft_edone), .fifo_wr_ce(fifo_wr_ce), .fifo_rd_ce(fifo_rd_ce),
    .fifo_hold(fifo_hold), .fft_start(fft_start), .fft_din_valid(fft_din_valid),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .overrun(overrun), .timeout(timeout), .err(err), .state(state)
  );

  // FIFO read-data-valid follows rd_ce by one cycle; noise adds spurious ready pulses.
  always @(posedge clk) rd_prev <= fifo_rd_ce;
  assign fifo_ready = rd_prev | noise;

  typedef struct packed {
    logic [1:0]  st;
    logic        wr, rd, hold, start, dv, done, ov, to, er;
    logic [15:0] fc, dc;
  } obs_t;

  obs_t expq[$];
  int tests = 0;
  int fails = 0;
  int cycle = 0;

  // Reference model: frame contents as a queue of sample ids.
  int m_mode, m_prev, m_waited, m_drops, m_sid;
  int m_frame[$];
  bit m_start, m_done, m_ov, m_to, m_er;
  logic [15:0] m_frames;

  task automatic m_reset();
    m_mode = IDLE; m_prev = IDLE; m_waited = 0; m_drops = 0;
    m_frame.delete();
    m_start = 0; m_done = 0; m_ov = 0; m_to = 0; m_er = 0; m_frames = 16'd0;
  endtask

  task automatic cyc(input bit en, input bit clr, input bit sv, input bit ferr,
                     input bit edone, input bit rst, input bit nz);
    obs_t e;
    bit drp;
    @(negedge clk);
    n_rst = ~rst; enable = en; clr_status = clr; sample_valid = sv;
    fifo_error = ferr; fft_edone = edone; noise = nz;
    e.st = 2'(m_mode);
    e.wr = (m_mode == FILL) && sv;
    e.rd = (m_mode == DRAIN);
    e.hold = (m_mode == IDLE) || (m_mode == WAITF);
    e.start = m_start;
    e.dv = ((m_prev == DRAIN) || nz) && ((m_mode == DRAIN) || (m_prev == DRAIN));
    e.done = m_done;
    e.ov = m_ov; e.to = m_to; e.er = m_er;
    e.fc = m_frames; e.dc = 16'(m_drops);
    expq.push_back(e);
    if (rst) begin
      m_reset();
      return;
    end
    drp = sv && (m_mode != FILL);
    m_prev = m_mode; m_start = 0; m_done = 0;
    if (clr) begin m_ov = 0; m_to = 0; m_er = 0; m_drops = 0; end
    if (drp) begin
      m_ov = 1;
      if (m_drops < 65535) m_drops++;
    end
    if (ferr) begin
      m_er = 1;
      m_mode = IDLE;
      m_frame.delete();
    end else begin
      case (m_mode)
        IDLE: begin
          m_frame.delete();
          if (en) m_mode = FILL;
        end
        FILL: begin
          if (sv) begin m_frame.push_back(m_sid); m_sid++; end
          if (!en) begin
            m_mode = IDLE;
            m_frame.delete();
          end else if (m_frame.size() == FRAME_LEN) begin
            m_mode = DRAIN;
            m_start = 1;
          end
        end
        DRAIN: begin
          void'(m_frame.pop_front());
          if (m_frame.size() == 0) begin m_mode = WAITF; m_waited = 0; end
        end
        default: begin
          m_waited++;
          if (edone) begin
            m_frames = m_frames + 16'd1;
            m_done = 1;
            m_mode = en ? FILL : IDLE;
          end else if (m_waited == TIMEOUT) begin
            m_to = 1;
            m_mode = IDLE;
          end
        end
      endcase
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL bound %s: model still in state %0d, required to leave it", name, m_mode);
  endtask

  // Monitor: pops one expectation for every observed cycle.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a.st = state; a.wr = fifo_wr_ce; a.rd = fifo_rd_ce; a.hold = fifo_hold;
        a.start = fft_start; a.dv = fft_din_valid; a.done = frame_done;
        a.ov = overrun; a.to = timeout; a.er = err; a.fc = frame_cnt; a.dc = drop_cnt;
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL cycle%0d outputs: got st=%0d wr=%b rd=%b hold=%b start=%b dv=%b done=%b ov=%b to=%b er=%b fc=%0d dc=%0d, required st=%0d wr=%b rd=%b hold=%b start=%b dv=%b done=%b ov=%b to=%b er=%b fc=%0d dc=%0d",
                   cycle, a.st, a.wr, a.rd, a.hold, a.start, a.dv, a.done, a.ov, a.to, a.er, a.fc, a.dc,
                   e.st, e.wr, e.rd, e.hold, e.start, e.dv, e.done, e.ov, e.to, e.er, e.fc, e.dc);
        end
      end
      cycle++;
    end
  end

  task automatic fill_frame(input int every, input string name);
    int k;
    k = 0;
    for (int g = 0; m_mode == FILL; g++) begin
      if (g > 2000) begin bound_fail(name); break; end
      cyc(1, 0, (k % every) == 0, 0, 0, 0, 0);
      k++;
    end
  endtask

  task automatic drain_frame(input bit sv, input string name);
    for (int g = 0; m_mode == DRAIN; g++) begin
      if (g > 200) begin bound_fail(name); break; end
      cyc(1, 0, sv, 0, 0, 0, 0);
    end
  endtask

  initial begin
    n_rst = 0; enable = 0; clr_status = 0; sample_valid = 0;
    fifo_error = 0; fft_edone = 0; noise = 0;
    m_sid = 0;
    m_reset();
    repeat (2) @(posedge clk);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Frame 1: back-to-back samples, edone after 50 WAIT cycles.
    cyc(1, 0, 0, 0, 0, 0, 0);
    fill_frame(1, "fill1");
    drain_frame(0, "drain1");
    repeat (50) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);

    // Frame 2: sparse samples, drops throughout DRAIN, then clear status.
    fill_frame(3, "fill2");
    drain_frame(1, "drain2");
    cyc(1, 1, 0, 0, 0, 0, 0);
    repeat (10) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);

    // Partial frame abort, refill, then FFT never completes.
    repeat (60) cyc(1, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    fill_frame(1, "fill3");
    drain_frame(0, "drain3");
    for (int g = 0; m_mode == WAITF; g++) begin
      if (g > TIMEOUT + 10) begin bound_fail("timeout"); break; end
      cyc(1, 0, 0, 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);

    // FIFO error mid-drain.
    cyc(1, 0, 0, 0, 0, 0, 0);
    fill_frame(1, "fill4");
    repeat (30) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Reset with 40 samples already read out.
    cyc(1, 0, 0, 0, 0, 0, 0);
    fill_frame(2, "fill5");
    repeat (40) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 6000; i++) begin
      cyc(($urandom % 16) != 0, ($urandom % 60) == 0, $urandom % 2,
          ($urandom % 700) == 0, ($urandom % 25) == 0,
          ($urandom % 2500) == 0, ($urandom % 8) == 0);
    end

    for (int g = 0; expq.size() > 0; g++) begin
      if (g > 10) begin bound_fail("drain_queue"); break; end
      @(negedge clk);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
